mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- Initiator-side load/store unit in the MEM stage; drives the word-wide data-memory port (combinational read, word write on clk) on behalf of the pipeline.
- Aligns lw/lh/lb/lhu/lbu results, turns sh/sb into a two-cycle read-modify-write, and classifies address exceptions before any write reaches memory.
- Sits between the pipeline MEM-stage registers and the data memory; the pipeline stalls on req_ready low.

Parameters:
- DM_TOP, 32'h00002FFF, last valid data-memory byte address (DM range is 0 to DM_TOP).
- DEV0_BASE, 32'h00007F00, device 0 window: DEV0_BASE to DEV0_BASE+7, word access only.
- DEV1_BASE, 32'h00007F10, device 1 window: DEV1_BASE to DEV1_BASE+7, word access only.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- req_valid  in  1  request present
- req_code  in  4  lw=0000 sw=0001 lh=0010 lb=0011 lhu=0100 lbu=0101 sh=0110 sb=0111 no=1000
- req_addr  in  32  byte address
- req_wdata  in  32  store data; low 16/8 bits used for sh/sb
- req_ready  out  1  unit can accept a request this cycle
- resp_valid  out  1  one-cycle pulse: request complete
- resp_rdata  out  32  extended load result; 0 for stores and exceptions
- resp_exc  out  2  00 ok, 10 load address error, 11 store address error
- mem_addr  out  32  word address to memory, {addr[31:2],2'b00}
- mem_wd  out  32  write word
- mem_we  out  1  write enable
- mem_rd  in  32  word read at mem_addr, same cycle

Behaviour:
- Reset (synchronous, active-high; clock clk):
  - state=IDLE; req_ready=1; resp_valid=0; resp_rdata=0; resp_exc=00; mem_we=0; mem_addr=0; mem_wd=0.
- Acceptance: a request is taken when req_valid=1, req_ready=1 and the code is 0000..0111. Code 1000 and undefined codes are ignored: no response, no state change.
- Exception check, combinational on the request:
  - misalign: lw/sw with addr[1:0]!=0; lh/lhu/sh with addr[0]!=0.
  - out of range: byte/half ops outside 0..DM_TOP; lw/sw outside DM and both device windows.
  - Load error gives 10, store error gives 11.
  - On error: no mem_we at any point, resp_rdata=0, resp_valid next cycle, state stays IDLE.
- FSM states: IDLE, RMW_WR.
- IDLE, load accepted:
  - mem_addr = word address; mem_rd is sampled this cycle.
  - Extraction is little-endian: byte k = mem_rd[8k+7:8k], half at addr[1]=h is mem_rd[16h+15:16h].
  - lb/lh sign-extend; lbu/lhu zero-extend.
  - The result registers into resp_rdata; resp_valid=1 next cycle. Latency is 1. req_ready stays 1, so back-to-back requests are allowed.
- IDLE, sw accepted:
  - mem_we=1, mem_wd=req_wdata, mem_addr=word address, all in the same cycle.
  - resp_valid next cycle. Latency is 1.
- IDLE, sh/sb accepted (read phase):
  - mem_addr = word address.
  - The merged word is latched: mem_rd with the selected lane replaced by req_wdata[15:0] or req_wdata[7:0].
  - Latch the address and go to RMW_WR.
- RMW_WR (write phase):
  - req_ready=0; mem_we=1; mem_wd = latched merged word; mem_addr = latched address.
  - Next cycle: IDLE and resp_valid=1. Total latency is 2; new requests are blocked for 1 cycle.
- Device-window stores (lw/sw only) are passed to the port like DM stores. Decoding the device select is the memory side's job.
- Outputs mem_addr, mem_wd and mem_we are combinational from the request in IDLE and registered in RMW_WR. mem_we=0 whenever no valid accepted store is in its write cycle.
- resp_valid is high for exactly 1 cycle per accepted request. resp_rdata and resp_exc hold until the next response.
- Reset during RMW_WR: the write is aborted (mem_we=0 that cycle), no response, return to IDLE.
- Address 0x00002FFF with sb is in range. 0x00003000 with any op is an error. 0x00007F04 with lw is ok. 0x00007F04 with lb is error 10.

Test Plan:
- mem_rd=0x8899AABB at word 0x10; lb 0x11 -> resp_rdata=0xFFFFFFAA; lbu 0x13 -> 0x00000088; lh 0x12 -> 0xFFFF8899; lhu 0x10 -> 0x0000AABB; each resp_valid 1 cycle later.
- Word 0x20 holds 0x11223344; sb 0x21 wdata=0x000000EE -> cycle0 read, cycle1 mem_we=1 mem_wd=0x1122EE44, req_ready=0 in cycle1, resp_valid cycle2; sh 0x22 wdata=0xBEEF -> mem_wd=0xBEEF3344.
- sw 0x7F10 wdata=0x5 -> mem_we=1 same cycle, mem_addr=0x7F10, resp_exc=00; sw 0x7F18 -> no write, resp_exc=11; lw 0x3000 -> resp_exc=10, resp_rdata=0.
- Misalign: lw 0x6 -> 10; sh 0x5 -> 11 with no mem_we; lhu 0x6 -> ok.
- Back-to-back lw,sw,lw on consecutive cycles -> three resp_valid pulses on consecutive cycles; code 1000 in between -> no pulse.
- Reset asserted in the RMW_WR cycle of sb 0x40 -> mem_we=0, no resp_valid, memory word unchanged, req_ready=1 after reset.

Source files
------------

// File: rtl/mem_access_unit.sv
// ============================================================================
// Module   : mem_access_unit
// Purpose  : MEM-stage load/store unit: load alignment, sub-word RMW stores,
//            address exception classification ahead of the data-memory port.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_access_unit #(
    parameter logic [31:0] DM_TOP    = 32'h00002FFF,
    parameter logic [31:0] DEV0_BASE = 32'h00007F00,
    parameter logic [31:0] DEV1_BASE = 32'h00007F10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic [3:0]  req_code,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        req_ready,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic [1:0]  resp_exc,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wd,
    output logic        mem_we,
    input  logic [31:0] mem_rd
);

    localparam logic [3:0] C_OP_LW  = 4'b0000;
    localparam logic [3:0] C_OP_SW  = 4'b0001;
    localparam logic [3:0] C_OP_LH  = 4'b0010;
    localparam logic [3:0] C_OP_LB  = 4'b0011;
    localparam logic [3:0] C_OP_LHU = 4'b0100;
    localparam logic [3:0] C_OP_LBU = 4'b0101;
    localparam logic [3:0] C_OP_SH  = 4'b0110;
    localparam logic [3:0] C_OP_SB  = 4'b0111;

    typedef enum logic [0:0] {
        S_IDLE   = 1'b0,
        S_RMW_WR = 1'b1
    } state_t;

    state_t      state_q,      state_d;
    logic        resp_valid_q, resp_valid_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;
    logic [1:0]  resp_exc_q,   resp_exc_d;
    logic [31:0] rmw_addr_q,   rmw_addr_d;
    logic [31:0] rmw_wd_q,     rmw_wd_d;

    logic        w_accept, w_is_word, w_is_half, w_is_store, w_sub_store;
    logic        w_misalign, w_in_dm, w_in_dev, w_err;
    logic [31:0] w_word_addr, w_shifted, w_load, w_merged;
    logic [15:0] w_half;

    always_comb begin
        w_accept    = req_valid && (state_q == S_IDLE) && !req_code[3] && !reset;
        w_is_word   = (req_code == C_OP_LW) || (req_code == C_OP_SW);
        w_is_half   = (req_code == C_OP_LH) || (req_code == C_OP_LHU) || (req_code == C_OP_SH);
        w_is_store  = (req_code == C_OP_SW) || (req_code == C_OP_SH) || (req_code == C_OP_SB);
        w_sub_store = (req_code == C_OP_SH) || (req_code == C_OP_SB);
        w_word_addr = {req_addr[31:2], 2'b00};

        w_misalign = (w_is_word && (req_addr[1:0] != 2'b00)) || (w_is_half && req_addr[0]);
        w_in_dm    = (req_addr <= DM_TOP);
        // Device windows are reachable by whole-word accesses only
        w_in_dev   = ((req_addr >= DEV0_BASE) && (req_addr <= DEV0_BASE + 32'd7)) ||
                     ((req_addr >= DEV1_BASE) && (req_addr <= DEV1_BASE + 32'd7));
        w_err      = w_misalign || !(w_in_dm || (w_is_word && w_in_dev));

        w_shifted = mem_rd >> {req_addr[1:0], 3'b000};
        w_half    = req_addr[1] ? mem_rd[31:16] : mem_rd[15:0];
        case (req_code)
            C_OP_LH:  w_load = {{16{w_half[15]}}, w_half};
            C_OP_LHU: w_load = {16'h0000, w_half};
            C_OP_LB:  w_load = {{24{w_shifted[7]}}, w_shifted[7:0]};
            C_OP_LBU: w_load = {24'h000000, w_shifted[7:0]};
            default:  w_load = mem_rd;
        endcase

        w_merged = mem_rd;
        if (req_code == C_OP_SH) begin
            if (req_addr[1]) w_merged = {req_wdata[15:0], mem_rd[15:0]};
            else             w_merged = {mem_rd[31:16], req_wdata[15:0]};
        end else begin
            case (req_addr[1:0])
                2'd0:    w_merged = {mem_rd[31:8], req_wdata[7:0]};
                2'd1:    w_merged = {mem_rd[31:16], req_wdata[7:0], mem_rd[7:0]};
                2'd2:    w_merged = {mem_rd[31:24], req_wdata[7:0], mem_rd[15:0]};
                default: w_merged = {req_wdata[7:0], mem_rd[23:0]};
            endcase
        end
    end

    always_comb begin
        state_d      = state_q;
        resp_valid_d = 1'b0;
        resp_rdata_d = resp_rdata_q;
        resp_exc_d   = resp_exc_q;
        rmw_addr_d   = rmw_addr_q;
        rmw_wd_d     = rmw_wd_q;
        mem_addr     = 32'h0;
        mem_wd       = 32'h0;
        mem_we       = 1'b0;

        if (state_q == S_RMW_WR) begin
            // Reset in the write cycle must not let the merged word land
            if (!reset) begin
                mem_addr = rmw_addr_q;
                mem_wd   = rmw_wd_q;
                mem_we   = 1'b1;
            end
            state_d      = S_IDLE;
            resp_valid_d = 1'b1;
            resp_rdata_d = 32'h0;
            resp_exc_d   = 2'b00;
        end else if (w_accept) begin
            if (w_err) begin
                resp_valid_d = 1'b1;
                resp_rdata_d = 32'h0;
                resp_exc_d   = w_is_store ? 2'b11 : 2'b10;
            end else if (w_sub_store) begin
                mem_addr   = w_word_addr;
                rmw_addr_d = w_word_addr;
                rmw_wd_d   = w_merged;
                state_d    = S_RMW_WR;
            end else begin
                mem_addr     = w_word_addr;
                mem_we       = w_is_store;
                mem_wd       = w_is_store ? req_wdata : 32'h0;
                resp_valid_d = 1'b1;
                resp_rdata_d = w_is_store ? 32'h0 : w_load;
                resp_exc_d   = 2'b00;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'h0;
            resp_exc_q   <= 2'b00;
            rmw_addr_q   <= 32'h0;
            rmw_wd_q     <= 32'h0;
        end else begin
            state_q      <= state_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_exc_q   <= resp_exc_d;
            rmw_addr_q   <= rmw_addr_d;
            rmw_wd_q     <= rmw_wd_d;
        end
    end

    assign req_ready  = (state_q == S_IDLE);
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_exc   = resp_exc_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_access_unit.sv
// ============================================================================
// Module   : tb_mem_access_unit
// Purpose  : Directed self-checking bench for mem_access_unit with a word memory.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic [3:0]  req_code = 4'h8;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        req_ready, resp_valid, mem_we;
    logic [31:0] resp_rdata, mem_addr, mem_wd, mem_rd;
    logic [1:0]  resp_exc;

    logic [31:0] mem [0:8191];
    logic        pl_we = 1'b0;
    logic [12:0] pl_idx = 13'h0;
    logic [31:0] pl_data = 32'h0;

    int n_vec = 0;
    int n_err = 0;

    logic [3:0]  ld_code [4] = '{4'h3, 4'h5, 4'h2, 4'h4};
    logic [31:0] ld_addr [4] = '{32'h11, 32'h13, 32'h12, 32'h10};
    logic [31:0] ld_exp  [4] = '{32'hFFFFFFAA, 32'h00000088, 32'hFFFF8899, 32'h0000AABB};

    mem_access_unit dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_code(req_code),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_exc(resp_exc),
        .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_we(mem_we), .mem_rd(mem_rd)
    );

    always #5 clk = ~clk;

    assign mem_rd = mem[mem_addr[14:2]];
    always @(posedge clk) begin
        if (pl_we)       mem[pl_idx] <= pl_data;
        else if (mem_we) mem[mem_addr[14:2]] <= mem_wd;
    end

    task automatic preload(input logic [12:0] idx, input logic [31:0] data);
        @(negedge clk);
        req_valid = 1'b0; pl_we = 1'b1; pl_idx = idx; pl_data = data;
        @(negedge clk);
        pl_we = 1'b0;
    endtask

    task automatic drive(input logic v, input logic [3:0] code, input logic [31:0] addr,
                         input logic [31:0] wd);
        @(negedge clk);
        req_valid = v; req_code = code; req_addr = addr; req_wdata = wd;
    endtask

    task automatic test_reset;
        repeat (2) @(posedge clk);
        #1;
        n_vec++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL rst_ready got %b want 1", req_ready); end
        n_vec++; if (resp_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid got %b want 0", resp_valid); end
        n_vec++; if (resp_rdata !== 32'h0) begin n_err++; $display("FAIL rst_rdata got %h want 0", resp_rdata); end
        n_vec++; if (resp_exc !== 2'b00) begin n_err++; $display("FAIL rst_exc got %b want 00", resp_exc); end
        n_vec++; if (mem_we !== 1'b0) begin n_err++; $display("FAIL rst_we got %b want 0", mem_we); end
        n_vec++; if (mem_addr !== 32'h0 || mem_wd !== 32'h0) begin n_err++; $display("FAIL rst_mem got addr=%h wd=%h want 0/0", mem_addr, mem_wd); end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_loads;
        preload(13'h4, 32'h8899AABB);
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, ld_code[i], ld_addr[i], 32'h0);
            #1;
            n_vec++; if (mem_addr !== 32'h10 || mem_we !== 1'b0) begin n_err++; $display("FAIL ld%0d_port got addr=%h we=%b want 00000010/0", i, mem_addr, mem_we); end
            @(posedge clk); #1;
            n_vec++; if (resp_valid !== 1'b1 || resp_rdata !== ld_exp[i] || resp_exc !== 2'b00) begin
                n_err++; $display("FAIL ld%0d_resp got v=%b d=%h e=%b want 1/%h/00", i, resp_valid, resp_rdata, resp_exc, ld_exp[i]); end
            drive(1'b0, 4'h8, 32'h0, 32'h0);
            @(posedge clk); #1;
            n_vec++; if (resp_valid !== 1'b0 || resp_rdata !== ld_exp[i]) begin n_err++; $display("FAIL ld%0d_hold got v=%b d=%h want 0/%h", i, resp_valid, resp_rdata, ld_exp[i]); end
        end
    endtask

    task automatic test_rmw;
        preload(13'h8, 32'h11223344);
        drive(1'b1, 4'h7, 32'h21, 32'h000000EE);
        #1;
        n_vec++; if (req_ready !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h20) begin n_err++; $display("FAIL sb_read got rdy=%b we=%b addr=%h want 1/0/00000020", req_ready, mem_we, mem_addr); end
        @(posedge clk); #1;
        n_vec++; if (req_ready !== 1'b0 || mem_we !== 1'b1 || mem_wd !== 32'h1122EE44 || mem_addr !== 32'h20 || resp_valid !== 1'b0) begin
            n_err++; $display("FAIL sb_write got rdy=%b we=%b wd=%h addr=%h v=%b want 0/1/1122EE44/00000020/0", req_ready, mem_we, mem_wd, mem_addr, resp_valid); end
        drive(1'b0, 4'h8, 32'h0, 32'h0);
        @(posedge clk); #1;
        n_vec++; if (resp_valid !== 1'b1 || resp_exc !== 2'b00 || req_ready !== 1'b1 || mem[8] !== 32'h1122EE44) begin
            n_err++; $display("FAIL sb_resp got v=%b e=%b rdy=%b mem=%h want 1/00/1/1122EE44", resp_valid, resp_exc, req_ready, mem[8]); end
        preload(13'h8, 32'h11223344);
        drive(1'b1, 4'h6, 32'h22, 32'h0000BEEF);
        @(posedge clk); #1;
        n_vec++; if (mem_we !== 1'b1 || mem_wd !== 32'hBEEF3344) begin n_err++; $display("FAIL sh_write got we=%b wd=%h want 1/BEEF3344", mem_we, mem_wd); end
        drive(1'b0, 4'h8, 32'h0, 32'h0);
        @(posedge clk); #1;
        n_vec++; if (resp_valid !== 1'b1 || mem[8] !== 32'hBEEF3344) begin n_err++; $display("FAIL sh_resp got v=%b mem=%h want 1/BEEF3344", resp_valid, mem[8]); end
    endtask

    task automatic test_device_exc;
        drive(1'b1, 4'h1, 32'h7F10, 32'h5);
        #1;
        n_vec++; if (mem_we !== 1'b1 || mem_addr !== 32'h7F10 || mem_wd !== 32'h5) begin n_err++; $display("FAIL sw_dev got we=%b addr=%h wd=%h want 1/00007F10/00000005", mem_we, mem_addr, mem_wd); end
        drive(1'b1, 4'h1, 32'h7F18, 32'h9);
        #1;
        n_vec++; if (resp_valid !== 1'b1 || resp_exc !== 2'b00) begin n_err++; $display("FAIL sw_dev_resp got v=%b e=%b want 1/00", resp_valid, resp_exc); end
        n_vec++; if (mem_we !== 1'b0) begin n_err++; $display("FAIL sw_bad_we got %b want 0", mem_we); end
        drive(1'b1, 4'h0, 32'h7F10, 32'h0);
        #1;
        n_vec++; if (resp_valid !== 1'b1 || resp_exc !== 2'b11) begin n_err++; $display("FAIL sw_bad_exc got v=%b e=%b want 1/11", resp_valid, resp_exc); end
        drive(1'b1, 4'h0, 32'h3000, 32'h0);
        #1;
        n_vec++; if (resp_rdata !== 32'h5 || resp_exc !== 2'b00) begin n_err++; $display("FAIL lw_dev got d=%h e=%b want 00000005/00", resp_rdata, resp_exc); end
        drive(1'b1, 4'h3, 32'h7F04, 32'h0);
        #1;
        n_vec++; if (resp_valid !== 1'b1 || resp_rdata !== 32'h0 || resp_exc !== 2'b10) begin n_err++; $display("FAIL lw_3000 got v=%b d=%h e=%b want 1/0/10", resp_valid, resp_rdata, resp_exc); end
        drive(1'b1, 4'h0, 32'h7F04, 32'h0);
        #1;
        n_vec++; if (resp_exc !== 2'b10) begin n_err++; $display("FAIL lb_dev got e=%b want 10", resp_exc); end
        drive(1'b1, 4'h7, 32'h2FFF, 32'h1);
        #1;
        n_vec++; if (resp_valid !== 1'b1 || resp_exc !== 2'b00) begin n_err++; $display("FAIL lw_dev04 got v=%b e=%b want 1/00", resp_valid, resp_exc); end
        @(posedge clk); #1;
        n_vec++; if (req_ready !== 1'b0 || mem_we !== 1'b1 || mem_addr !== 32'h2FFC) begin n_err++; $display("FAIL sb_top got rdy=%b we=%b addr=%h want 0/1/00002FFC", req_ready, mem_we, mem_addr); end
        drive(1'b0, 4'h8, 32'h0, 32'h0);
        @(posedge clk); #1;
        n_vec++; if (resp_valid !== 1'b1 || resp_exc !== 2'b00) begin n_err++; $display("FAIL sb_top_resp got v=%b e=%b want 1/00", resp_valid, resp_exc); end
    endtask

    task automatic test_misalign;
        preload(13'h1, 32'h12345678);
        drive(1'b1, 4'h0, 32'h6, 32'h0);
        @(posedge clk); #1;
        n_vec++; if (resp_valid !== 1'b1 || resp_exc !== 2'b10 || resp_rdata !== 32'h0) begin n_err++; $display("FAIL lw_mis got v=%b e=%b d=%h want 1/10/0", resp_valid, resp_exc, resp_rdata); end
        drive(1'b1, 4'h6, 32'h5, 32'hFFFF);
        #1;
        n_vec++; if (mem_we !== 1'b0) begin n_err++; $display("FAIL sh_mis_we0 got %b want 0", mem_we); end
        drive(1'b1, 4'h4, 32'h6, 32'h0);
        #1;
        n_vec++; if (resp_exc !== 2'b11 || mem_we !== 1'b0 || req_ready !== 1'b1) begin n_err++; $display("FAIL sh_mis got e=%b we=%b rdy=%b want 11/0/1", resp_exc, mem_we, req_ready); end
        @(posedge clk); #1;
        n_vec++; if (resp_valid !== 1'b1 || resp_exc !== 2'b00 || resp_rdata !== 32'h00001234) begin n_err++; $display("FAIL lhu_6 got v=%b e=%b d=%h want 1/00/00001234", resp_valid, resp_exc, resp_rdata); end
        n_vec++; if (mem[1] !== 32'h12345678) begin n_err++; $display("FAIL mis_mem got %h want 12345678", mem[1]); end
    endtask

    task automatic test_back_to_back;
        drive(1'b1, 4'h0, 32'h10, 32'h0);
        @(posedge clk); #1;
        n_vec++; if (resp_valid !== 1'b1 || resp_rdata !== 32'h8899AABB) begin n_err++; $display("FAIL b2b_lw1 got v=%b d=%h want 1/8899AABB", resp_valid, resp_rdata); end
        drive(1'b1, 4'h1, 32'h30, 32'hCAFEF00D);
        @(posedge clk); #1;
        n_vec++; if (resp_valid !== 1'b1 || resp_rdata !== 32'h0) begin n_err++; $display("FAIL b2b_sw got v=%b d=%h want 1/0", resp_valid, resp_rdata); end
        drive(1'b1, 4'h0, 32'h30, 32'h0);
        @(posedge clk); #1;
        n_vec++; if (resp_valid !== 1'b1 || resp_rdata !== 32'hCAFEF00D) begin n_err++; $display("FAIL b2b_lw2 got v=%b d=%h want 1/CAFEF00D", resp_valid, resp_rdata); end
        drive(1'b1, 4'h8, 32'h30, 32'h1);
        #1;
        n_vec++; if (mem_we !== 1'b0) begin n_err++; $display("FAIL nop_we got %b want 0", mem_we); end
        @(posedge clk); #1;
        n_vec++; if (resp_valid !== 1'b0) begin n_err++; $display("FAIL nop_valid got %b want 0", resp_valid); end
        drive(1'b1, 4'h0, 32'h10, 32'h0);
        @(posedge clk); #1;
        n_vec++; if (resp_valid !== 1'b1 || resp_rdata !== 32'h8899AABB) begin n_err++; $display("FAIL b2b_lw3 got v=%b d=%h want 1/8899AABB", resp_valid, resp_rdata); end
        drive(1'b0, 4'h8, 32'h0, 32'h0);
    endtask

    task automatic test_reset_rmw;
        preload(13'h10, 32'hA5A5A5A5);
        drive(1'b1, 4'h7, 32'h40, 32'h77);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1; req_valid = 1'b0;
        #1;
        n_vec++; if (mem_we !== 1'b0) begin n_err++; $display("FAIL rst_rmw_we got %b want 0", mem_we); end
        @(posedge clk); #1;
        n_vec++; if (resp_valid !== 1'b0 || req_ready !== 1'b1 || mem[16] !== 32'hA5A5A5A5) begin
            n_err++; $display("FAIL rst_rmw got v=%b rdy=%b mem=%h want 0/1/A5A5A5A5", resp_valid, req_ready, mem[16]); end
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        n_vec++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin n_err++; $display("FAIL rst_rmw_after got v=%b rdy=%b want 0/1", resp_valid, req_ready); end
    endtask

    initial begin
        test_reset();
        test_loads();
        test_rmw();
        test_device_exc();
        test_misalign();
        test_back_to_back();
        test_reset_rmw();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
